i2c_write_master: RTL and testbench
===================================

Name: i2c_write_master

Overview:
- I2C/SCCB write-only bus master. It is the responder end of the register-map sequencer's request/done handshake.
- Accepts one write word per request: {reg_addr, reg_data}, MSB first. Drives a START, the device address with W bit, each data byte with a 9th ACK slot, then a STOP on an open-drain SCL/SDA pair.
- Pulses done after each transfer. Also pulses done once after reset, to kick the sequencer into issuing its first request.

Parameters:
- CLK_FREQ, 50_000_000: i_clk frequency in Hz.
- I2C_FREQ, 250_000: SCL frequency in Hz. Quarter-bit divider DIV = CLK_FREQ/(4*I2C_FREQ), must be ≥2.
- SLAVE_ADDR, 7'h21: 7-bit device address. First byte sent = {SLAVE_ADDR, 1'b0}.
- REG_WIDTH, 16: write word width. Must be a multiple of 8. Payload bytes NB = REG_WIDTH/8.
- STARTUP_CYCLES, 1000: i_clk cycles from reset release to the initial done pulse.

Ports:
- i_clk, in, 1: single clock.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_i2c_req, in, 1: one-cycle request strobe; accepted only in IDLE.
- i_i2c_data, in, REG_WIDTH: write word; captured in the cycle req is accepted.
- o_i2c_done, out, 1: one-cycle pulse at startup and at end of each transfer.
- o_busy, out, 1: high from request acceptance until the done pulse.
- o_ack_err, out, 1: set if any ACK slot of the last transfer sampled SDA high. Updated with done.
- o_scl, out, 1: SCL level (1 = released/high).
- o_sda_oe, out, 1: 1 = pull SDA low, 0 = release.
- i_sda, in, 1: SDA pad input, sampled in ACK slots.

Behaviour:
- Reset values (applied asynchronously while i_rst=1, mid-transfer included):
  - o_scl=1, o_sda_oe=0, o_i2c_done=0, o_busy=0, o_ack_err=0.
  - State = WAIT; all counters = 0; shift register = 0.
- Tick: free-running divider emits a one-cycle tick every DIV cycles, active only while busy. Divider is cleared on request acceptance. One bit period = 4 ticks, numbered q0..q3.
- FSM states: WAIT, IDLE, START, BYTE, ACK, STOP, FIN.
- WAIT:
  - Counts STARTUP_CYCLES.
  - Then asserts o_i2c_done for exactly 1 cycle and goes to IDLE.
- IDLE:
  - On i_i2c_req: latch {SLAVE_ADDR,0,i_i2c_data} into shift register; byte_cnt=0; o_busy=1; go to START.
  - A req in any other state is ignored. No queueing.
- START (one bit period):
  - q0: SCL=1, SDA released.
  - q2: SDA pulled low.
  - q3: SCL=0.
  - Then go to BYTE with bit_cnt=7.
- BYTE (8 bit periods, MSB first), per bit:
  - q0: SCL=0, SDA = ~bit.
  - q1 and q2: SCL=1.
  - q3: SCL=0.
  - After bit 0, go to ACK.
- ACK (one bit period):
  - SDA released; SCL pattern as BYTE.
  - Sample i_sda at q2; if 1, set internal err flag.
  - Then: if byte_cnt<NB, increment byte_cnt and go to BYTE; else go to STOP.
- STOP:
  - q0: SDA low, SCL=0.
  - q1: SCL=1.
  - q3: SDA released.
  - Then go to FIN.
- FIN (1 cycle): o_i2c_done=1; o_ack_err=err; err cleared; o_busy=0; go to IDLE.
- Transfer length: (1 + 9*(NB+1) + 1) bit periods = 29 bit periods for REG_WIDTH=16.
  - Done pulse occurs 29*4*DIV + 1 cycles after the accept cycle.
- An ACK error does not abort the transfer (SCCB devices may not ACK). It is only reported.
- SDA changes only while SCL=0, except the START and STOP edges.
- Reset mid-transfer returns to WAIT. After STARTUP_CYCLES a fresh startup done pulse is emitted.

Decomposition:
- Shared package i2c_pkg:
  - FSM state enum.
  - Divider width function, clog2-based.
  - Bit-phase constants Q0..Q3.
- One sub-module: i2c_tick_gen. Parameterised divider producing the tick and the q-phase counter.

Test Plan:
- CLK_FREQ=4_000_000, I2C_FREQ=250_000 (DIV=4), STARTUP_CYCLES=10. Release reset -> exactly one o_i2c_done pulse at cycle 10; o_scl=1, o_sda_oe=0 throughout.
- Req with data 16'h1280, bus model ACKs -> SDA bytes decoded on SCL rising edges are 0x42, 0x12, 0x80. START/STOP detected once each. Done at accept+465 cycles; o_ack_err=0.
- Same req with i_sda held 1 -> transfer still completes in 465 cycles; o_ack_err=1. Next transfer with ACKs -> o_ack_err=0.
- Second req asserted mid-transfer -> ignored. Exactly one transfer on the bus and one done pulse.
- i_rst asserted during the second payload byte -> o_scl=1 and o_sda_oe=0 in the same cycle. New startup done pulse 10 cycles after release; no STOP emitted.
- Chain with the register-map sequencer (70 entries) -> 70 transfers. Final SDA payload {0x09,0x00}; sequencer init_done asserts after the 70th done.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM encoding, bit-phase constants and divider sizing for the I2C write master.
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_BYTE  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5,
        ST_FIN   = 3'd6
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    function automatic int div_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-bit tick divider plus the q0..q3 phase counter within a bit period.
`default_nettype none

module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int              W    = div_width(DIV);
    localparam logic [W-1:0]    LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                phase <= phase + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_write_master.sv
// i2c_write_master: write-only I2C/SCCB master; sends START, {addr,W}, payload bytes with ACK slots, STOP.
`default_nettype none

module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int         CLK_FREQ       = 50_000_000,
    parameter int         I2C_FREQ       = 250_000,
    parameter logic [6:0] SLAVE_ADDR     = 7'h21,
    parameter int         REG_WIDTH      = 16,
    parameter int         STARTUP_CYCLES = 1000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_i2c_req,
    input  logic [REG_WIDTH-1:0] i_i2c_data,
    output logic                 o_i2c_done,
    output logic                 o_busy,
    output logic                 o_ack_err,
    output logic                 o_scl,
    output logic                 o_sda_oe,
    input  logic                 i_sda
);

    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);
    localparam int NB  = REG_WIDTH / 8;
    localparam int SW  = REG_WIDTH + 8;
    localparam int CW  = $clog2(STARTUP_CYCLES + 1);
    localparam int BW  = $clog2(NB + 1);

    state_t          state, state_nxt;
    logic [SW-1:0]   shift, shift_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [BW-1:0]   byte_cnt, byte_nxt;
    logic [CW-1:0]   wait_cnt, wait_nxt;
    logic            err, err_nxt;
    logic            busy_nxt, done_nxt, ack_err_nxt, scl_nxt, oe_nxt;
    logic            accept, tick;
    logic [1:0]      phase;
    logic            sda_meta, sda_sync;

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .clk   (i_clk),
        .rst   (i_rst),
        .en    (o_busy),
        .clr   (accept),
        .tick  (tick),
        .phase (phase)
    );

    // Pad input is asynchronous to i_clk; ACK is sampled well after SCL rises so two flops cost nothing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= i_sda;
            sda_sync <= sda_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_WAIT;
            shift      <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            err        <= 1'b0;
            o_busy     <= 1'b0;
            o_i2c_done <= 1'b0;
            o_ack_err  <= 1'b0;
            o_scl      <= 1'b1;
            o_sda_oe   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_nxt;
            byte_cnt   <= byte_nxt;
            wait_cnt   <= wait_nxt;
            err        <= err_nxt;
            o_busy     <= busy_nxt;
            o_i2c_done <= done_nxt;
            o_ack_err  <= ack_err_nxt;
            o_scl      <= scl_nxt;
            o_sda_oe   <= oe_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_nxt     = bit_cnt;
        byte_nxt    = byte_cnt;
        wait_nxt    = wait_cnt;
        err_nxt     = err;
        busy_nxt    = o_busy;
        done_nxt    = 1'b0;
        ack_err_nxt = o_ack_err;
        accept      = 1'b0;
        scl_nxt     = 1'b1;
        oe_nxt      = 1'b0;
        case (state)
            ST_WAIT: begin
                if (wait_cnt == CW'(STARTUP_CYCLES - 1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_i2c_req) begin
                    accept    = 1'b1;
                    shift_nxt = {SLAVE_ADDR, 1'b0, i_i2c_data};
                    byte_nxt  = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                oe_nxt  = (phase == Q2) || (phase == Q3);
                scl_nxt = (phase != Q3);
                if (tick && phase == Q3) begin
                    bit_nxt   = 3'd7;
                    state_nxt = ST_BYTE;
                end
            end
            ST_BYTE: begin
                oe_nxt  = ~shift[SW-1];
                scl_nxt = (phase == Q1) || (phase == Q2);
                if (tick && phase == Q3) begin
                    shift_nxt = {shift[SW-2:0], 1'b0};
                    if (bit_cnt == 3'd0) state_nxt = ST_ACK;
                    else                 bit_nxt   = bit_cnt - 3'd1;
                end
            end
            ST_ACK: begin
                scl_nxt = (phase == Q1) || (phase == Q2);
                if (tick && phase == Q2 && sda_sync) err_nxt = 1'b1;
                if (tick && phase == Q3) begin
                    if (byte_cnt < BW'(NB)) begin
                        byte_nxt  = byte_cnt + 1'b1;
                        bit_nxt   = 3'd7;
                        state_nxt = ST_BYTE;
                    end else begin
                        state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                oe_nxt  = (phase != Q3);
                scl_nxt = (phase != Q0);
                if (tick && phase == Q3) state_nxt = ST_FIN;
            end
            ST_FIN: begin
                done_nxt    = 1'b1;
                ack_err_nxt = err;
                err_nxt     = 1'b0;
                busy_nxt    = 1'b0;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_WAIT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: bus-level monitor + ACKing slave model; checks decoded bytes, timing and flags.
`default_nettype none

module tb_i2c_write_master;

    localparam logic [6:0] ADDR = 7'h21;
    localparam int         LAT  = 29 * 4 * 4 + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [15:0] data = 16'h0;
    logic        done, busy, ack_err, scl, sda_oe, sda_in;

    logic        slave_pull = 1'b0;
    logic        ack_en = 1'b1;
    logic        scl_d = 1'b1, sda_d = 1'b1;
    logic [7:0]  cur = 8'h0;
    int          nbits = 0, start_cnt = 0, stop_cnt = 0, done_cnt = 0;
    logic [7:0]  byte_q[$];
    int          errors = 0, checks = 0;

    wire sda_line = ~sda_oe & ~slave_pull;
    assign sda_in = sda_line;

    always #5 clk = ~clk;

    i2c_write_master #(
        .CLK_FREQ(4_000_000), .I2C_FREQ(250_000), .SLAVE_ADDR(ADDR),
        .REG_WIDTH(16), .STARTUP_CYCLES(10)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_i2c_req(req), .i_i2c_data(data),
        .o_i2c_done(done), .o_busy(busy), .o_ack_err(ack_err),
        .o_scl(scl), .o_sda_oe(sda_oe), .i_sda(sda_in)
    );

    // Open-drain bus observer and a slave that pulls SDA low through each 9th clock.
    always @(negedge clk) begin
        if (rst) begin
            slave_pull <= 1'b0;
            nbits      <= 0;
            scl_d      <= 1'b1;
            sda_d      <= 1'b1;
        end else begin
            if (scl_d && scl && sda_d && !sda_line) begin
                start_cnt <= start_cnt + 1;
                nbits     <= 0;
            end else if (scl_d && scl && !sda_d && sda_line) begin
                stop_cnt <= stop_cnt + 1;
            end else if (!scl_d && scl) begin
                nbits <= nbits + 1;
                if ((nbits % 9) < 8) begin
                    cur <= {cur[6:0], sda_line};
                    if ((nbits % 9) == 7) byte_q.push_back({cur[6:0], sda_line});
                end
            end else if (scl_d && !scl) begin
                slave_pull <= ack_en && ((nbits % 9) == 8);
            end
            scl_d <= scl;
            sda_d <= sda_line;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_startup(input string tag);
        int first = 0, pulses = 0;
        bit idle_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (scl !== 1'b1 || sda_oe !== 1'b0) idle_ok = 1'b0;
        end
        chk({tag, "_done_cycle"}, first, 10);
        chk({tag, "_done_pulses"}, pulses, 1);
        chk({tag, "_bus_idle"}, idle_ok, 1'b1);
    endtask

    // One transfer; expectations come from the byte sequence {addr,W}, hi, lo and fixed frame length.
    task automatic do_xfer(input logic [15:0] d, input bit ack, input int extra_req_at);
        int s0, p0, dc0, lat;
        logic [7:0] exp_b[3];
        logic [7:0] obs;
        exp_b[0] = {ADDR, 1'b0};
        exp_b[1] = d[15:8];
        exp_b[2] = d[7:0];
        ack_en = ack;
        byte_q.delete();
        s0 = start_cnt; p0 = stop_cnt; dc0 = done_cnt; lat = 0;
        @(posedge clk); #1;
        req = 1'b1; data = d;
        @(posedge clk); #1;
        req = 1'b0; data = 16'($urandom);
        chk("busy_after_accept", busy, 1'b1);
        for (int k = 1; k <= 600; k++) begin
            @(posedge clk); #1;
            req = (k == extra_req_at);
            if (done) begin
                lat = k;
                break;
            end
        end
        req = 1'b0;
        chk("done_latency", lat, LAT);
        @(negedge clk); #1;
        chk("done_count", done_cnt - dc0, 1);
        chk("busy_cleared", busy, 1'b0);
        chk("ack_err", ack_err, !ack);
        chk("start_count", start_cnt - s0, 1);
        chk("stop_count", stop_cnt - p0, 1);
        chk("byte_count", byte_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            obs = (i < byte_q.size()) ? byte_q[i] : 8'hxx;
            chk($sformatf("byte%0d", i), obs, exp_b[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tbl[70];
        int s0, p0, dc0, found;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", scl, 1'b1);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        rst = 1'b0;
        wait_startup("startup");

        do_xfer(16'h1280, 1'b1, 0);
        do_xfer(16'h1280, 1'b0, 0);
        do_xfer(16'h1280, 1'b1, 0);

        for (int i = 0; i < 6; i++) do_xfer(16'($urandom), 1'($urandom_range(0, 1)), 0);

        // Second request mid-transfer must leave exactly one frame and one done pulse.
        do_xfer(16'hA5C3, 1'b1, 100);
        s0 = start_cnt; dc0 = done_cnt;
        repeat (500) @(posedge clk);
        #1;
        chk("ignored_req_no_start", start_cnt - s0, 0);
        chk("ignored_req_no_done", done_cnt - dc0, 0);

        // Reset during the second payload byte, with SCL low.
        ack_en = 1'b1;
        byte_q.delete();
        p0 = stop_cnt; found = 0;
        @(posedge clk); #1;
        req = 1'b1; data = 16'h5AF0;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            if (byte_q.size() == 2 && scl == 1'b0 && (nbits % 9) >= 2 && (nbits % 9) <= 5) begin
                found = 1;
                break;
            end
        end
        chk("reset_point_found", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_scl", scl, 1'b1);
        chk("midrst_sda_oe", sda_oe, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_startup("restart");
        chk("midrst_no_stop", stop_cnt - p0, 0);

        // Sequencer chain: each done triggers the next table entry.
        for (int i = 0; i < 69; i++) tbl[i] = 16'($urandom);
        tbl[69] = 16'h0900;
        dc0 = done_cnt;
        for (int i = 0; i < 70; i++) do_xfer(tbl[i], 1'b1, 0);
        chk("chain_done_count", done_cnt - dc0, 70);
        chk("chain_last_hi", (byte_q.size() == 3) ? byte_q[1] : 8'hxx, 8'h09);
        chk("chain_last_lo", (byte_q.size() == 3) ? byte_q[2] : 8'hxx, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
